vga_sprite_compositor: RTL and testbench

Parametrised, pipelined sprite compositor for the VGA path. It takes one screen pixel request per clock (drawx/drawy plus a background colour) and looks up NUM_SPRITES sprite RAMs through their second port. It returns the composited 16-bit colour using fixed index priority, colour-key transparency, per-sprite flips, frame-synchronous double-buffered parameters and sticky collision detection. Software programs it through a 32-bit Avalon-MM slave; it replaces the fixed 8-sprite parameter pass-through.

---
 rtl/vga_sprite_compositor_if.sv | 19 +
 rtl/vga_sprite_compositor.sv | 246 ++++++++++++++++++++++++
 tb/tb_vga_sprite_compositor.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sprite_compositor_if.sv
// Avalon-MM register bus for the sprite compositor.
//   avs_address   : register word address (8 bits)
//   avs_read      : read strobe, data returned one cycle later
//   avs_write     : write strobe, zero wait states
//   avs_writedata : 32-bit write data
//   avs_readdata  : 32-bit registered read data
// slave modport is used by the compositor, master modport by the bus owner.
interface vga_sprite_compositor_if;
    logic [7:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport slave  (input  avs_address, avs_read, avs_write, avs_writedata,
                    output avs_readdata);
    modport master (output avs_address, avs_read, avs_write, avs_writedata,
                    input  avs_readdata);
endinterface

// File: rtl/vga_sprite_compositor.sv
// Pipelined sprite compositor for the VGA path.
// For every screen pixel request it hit-tests NUM_SPRITES sprites, addresses
// each sprite RAM through its second port, and returns the colour of the
// lowest-indexed opaque sprite (or the background). Sprite parameters are
// double buffered and swap in at frame_start after a COMMIT; overlapping
// opaque sprites raise sticky collision flags.
//
// Ports:
//   clk_clk, reset_reset : clock, synchronous active-high reset
//   avs                  : Avalon-MM register slave (see interface file)
//   frame_start          : one-cycle pulse at start of vertical blank
//   pix_valid_in, drawx, drawy, bg_pixel : pixel request
//   pix_valid_out, pix_out               : composited result, 3 cycles later
//   spr_address, spr_chipselect, spr_clken : per-sprite RAM read port
//   spr_readdata                           : per-sprite RAM data, 1-cycle latency
module vga_sprite_compositor #(
    parameter int                NUM_SPRITES = 8,
    parameter int                SPRITE_W    = 32,
    parameter int                SPRITE_H    = 64,
    parameter int                ADDR_W      = 11,
    parameter int                PIX_W       = 16,
    parameter logic [PIX_W-1:0]  KEY_COLOR   = 16'hF81F
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset,
    vga_sprite_compositor_if.slave        avs,
    input  logic                          frame_start,
    input  logic                          pix_valid_in,
    input  logic [9:0]                    drawx,
    input  logic [9:0]                    drawy,
    input  logic [PIX_W-1:0]              bg_pixel,
    output logic                          pix_valid_out,
    output logic [PIX_W-1:0]              pix_out,
    output logic [NUM_SPRITES*ADDR_W-1:0] spr_address,
    output logic [NUM_SPRITES-1:0]        spr_chipselect,
    output logic [NUM_SPRITES-1:0]        spr_clken,
    input  logic [NUM_SPRITES*PIX_W-1:0]  spr_readdata
);

    localparam int SPR_WORDS = 4 * NUM_SPRITES;

    // Shadow (software-visible) and active (pixel pipeline) parameters.
    // ctrl: [0] enable, [1] flip_x, [2] flip_y. x/y are 11-bit signed.
    logic [2:0]  sh_ctrl  [NUM_SPRITES];
    logic [10:0] sh_x     [NUM_SPRITES];
    logic [10:0] sh_y     [NUM_SPRITES];
    logic [2:0]  act_ctrl [NUM_SPRITES];
    logic [10:0] act_x    [NUM_SPRITES];
    logic [10:0] act_y    [NUM_SPRITES];

    logic                   commit_pending;
    logic [NUM_SPRITES-1:0] collision;

    // Register decode
    logic [5:0]             reg_idx;
    logic [1:0]             reg_sel;
    logic                   spr_space;
    logic [NUM_SPRITES-1:0] wr_spr;
    logic                   commit_wr;
    logic                   do_commit;
    logic [NUM_SPRITES-1:0] coll_clr;
    logic [31:0]            rd_mux;

    // Pixel pipeline
    logic signed [11:0]     rx [NUM_SPRITES];
    logic signed [11:0]     ry [NUM_SPRITES];
    logic [11:0]            ax [NUM_SPRITES];
    logic [11:0]            ay [NUM_SPRITES];
    logic [31:0]            addr_full [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] hit;

    logic                   vld_p0, vld_p1;
    logic [NUM_SPRITES-1:0] hit_p0, hit_p1;
    logic [PIX_W-1:0]       bg_p0, bg_p1;

    logic [NUM_SPRITES-1:0] opaque;
    logic [PIX_W-1:0]       win_pix;
    logic                   multi_hit;
    logic [NUM_SPRITES-1:0] coll_set;

    logic                   unused_bits;

    assign reg_idx   = avs.avs_address[7:2];
    assign reg_sel   = avs.avs_address[1:0];
    assign spr_space = (9'(avs.avs_address) < 9'(SPR_WORDS));
    assign commit_wr = avs.avs_write && (avs.avs_address == 8'hFF) && avs.avs_writedata[0];
    assign do_commit = frame_start && commit_pending;
    assign coll_clr  = (avs.avs_write && (avs.avs_address == 8'hFD))
                       ? avs.avs_writedata[NUM_SPRITES-1:0] : '0;

    always_comb begin
        wr_spr = '0;
        rd_mux = '0;
        for (int n = 0; n < NUM_SPRITES; n++) begin
            if (spr_space && (reg_idx == 6'(n))) begin
                wr_spr[n] = avs.avs_write;
                case (reg_sel)
                    2'd0:    rd_mux = {29'd0, sh_ctrl[n]};
                    2'd1:    rd_mux = {5'd0, sh_y[n], 5'd0, sh_x[n]};
                    default: rd_mux = '0;
                endcase
            end
        end
        case (avs.avs_address)
            8'hFD:   rd_mux = 32'(collision);
            8'hFE:   rd_mux = {31'd0, commit_pending};
            default: ;
        endcase
    end

    // Shadow writes and frame-synchronous commit. The active copy takes the
    // shadow value from before any write landing in the same cycle.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            for (int n = 0; n < NUM_SPRITES; n++) begin
                sh_ctrl[n]  <= '0;
                sh_x[n]     <= '0;
                sh_y[n]     <= '0;
                act_ctrl[n] <= '0;
                act_x[n]    <= '0;
                act_y[n]    <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_SPRITES; n++) begin
                if (wr_spr[n] && (reg_sel == 2'd0)) begin
                    sh_ctrl[n] <= avs.avs_writedata[2:0];
                end
                if (wr_spr[n] && (reg_sel == 2'd1)) begin
                    sh_x[n] <= avs.avs_writedata[10:0];
                    sh_y[n] <= avs.avs_writedata[26:16];
                end
                if (do_commit) begin
                    act_ctrl[n] <= sh_ctrl[n];
                    act_x[n]    <= sh_x[n];
                    act_y[n]    <= sh_y[n];
                end
            end
        end
    end

    // A COMMIT write coinciding with frame_start re-arms for the next frame.
    // A new collision wins over a W1C on the same bit.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            commit_pending   <= 1'b0;
            collision        <= '0;
            avs.avs_readdata <= '0;
        end else begin
            if (commit_wr) begin
                commit_pending <= 1'b1;
            end else if (do_commit) begin
                commit_pending <= 1'b0;
            end
            collision <= (collision & ~coll_clr) | coll_set;
            if (avs.avs_read) begin
                avs.avs_readdata <= rd_mux;
            end
        end
    end

    // Hit test and RAM address. Coordinates are zero-extended to 12-bit
    // signed so drawx up to 1023 never aliases onto a negative offset.
    always_comb begin
        hit = '0;
        for (int n = 0; n < NUM_SPRITES; n++) begin
            rx[n] = $signed({2'b00, drawx}) - $signed({act_x[n][10], act_x[n]});
            ry[n] = $signed({2'b00, drawy}) - $signed({act_y[n][10], act_y[n]});
            hit[n] = act_ctrl[n][0]
                     && !rx[n][11] && ({1'b0, rx[n][10:0]} < 12'(SPRITE_W))
                     && !ry[n][11] && ({1'b0, ry[n][10:0]} < 12'(SPRITE_H));
            ax[n] = act_ctrl[n][1] ? (12'(SPRITE_W - 1) - $unsigned(rx[n])) : $unsigned(rx[n]);
            ay[n] = act_ctrl[n][2] ? (12'(SPRITE_H - 1) - $unsigned(ry[n])) : $unsigned(ry[n]);
            addr_full[n] = 32'(ay[n]) * 32'(SPRITE_W) + 32'(ax[n]);
        end
    end

    always_comb begin
        unused_bits = ^avs.avs_writedata;
        for (int n = 0; n < NUM_SPRITES; n++) begin
            unused_bits = unused_bits ^ (^addr_full[n]);
        end
    end

    // ---- Stage p0: request registered, RAM address issued ----
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            vld_p0         <= 1'b0;
            hit_p0         <= '0;
            spr_chipselect <= '0;
            spr_clken      <= '0;
        end else begin
            vld_p0         <= pix_valid_in;
            hit_p0         <= pix_valid_in ? hit : '0;
            spr_chipselect <= pix_valid_in ? hit : '0;
            spr_clken      <= pix_valid_in ? hit : '0;
        end
    end

    always_ff @(posedge clk_clk) begin
        bg_p0 <= bg_pixel;
        for (int n = 0; n < NUM_SPRITES; n++) begin
            spr_address[n*ADDR_W +: ADDR_W] <= addr_full[n][ADDR_W-1:0];
        end
    end

    // ---- Stage p1: waiting on RAM read latency ----
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            vld_p1 <= 1'b0;
            hit_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            hit_p1 <= hit_p0;
        end
    end

    always_ff @(posedge clk_clk) begin
        bg_p1 <= bg_p0;
    end

    // Priority select: scan downward so the lowest opaque index wins.
    // Two or more opaque sprites: clearing the lowest set bit leaves a one.
    always_comb begin
        win_pix = bg_p1;
        for (int n = NUM_SPRITES - 1; n >= 0; n--) begin
            opaque[n] = hit_p1[n] && (spr_readdata[n*PIX_W +: PIX_W] != KEY_COLOR);
            if (opaque[n]) begin
                win_pix = spr_readdata[n*PIX_W +: PIX_W];
            end
        end
        multi_hit = |(opaque & (opaque - NUM_SPRITES'(1)));
        coll_set  = (vld_p1 && multi_hit) ? opaque : '0;
    end

    // ---- Stage p2: composited output ----
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            pix_valid_out <= 1'b0;
            pix_out       <= '0;
        end else begin
            pix_valid_out <= vld_p1;
            pix_out       <= win_pix;
        end
    end

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Self-checking bench for vga_sprite_compositor: behavioural sprite RAMs,
// register/pixel model, and a scoreboard of expected pixels keyed by the
// cycle at which each result must appear.
module tb_vga_sprite_compositor;
    localparam int          NS  = 8;
    localparam int          SW  = 32;
    localparam int          SH  = 64;
    localparam int          AW  = 11;
    localparam int          PW  = 16;
    localparam logic [15:0] KEY = 16'hF81F;

    logic              clk = 1'b0;
    logic              rst;
    logic              frame_start;
    logic              pix_valid_in;
    logic [9:0]        drawx, drawy;
    logic [PW-1:0]     bg_pixel;
    logic              pix_valid_out;
    logic [PW-1:0]     pix_out;
    logic [NS*AW-1:0]  spr_address;
    logic [NS-1:0]     spr_chipselect, spr_clken;
    logic [NS*PW-1:0]  spr_readdata;

    vga_sprite_compositor_if avs_if ();

    vga_sprite_compositor #(
        .NUM_SPRITES(NS), .SPRITE_W(SW), .SPRITE_H(SH),
        .ADDR_W(AW), .PIX_W(PW), .KEY_COLOR(KEY)
    ) dut (
        .clk_clk       (clk),
        .reset_reset   (rst),
        .avs           (avs_if),
        .frame_start   (frame_start),
        .pix_valid_in  (pix_valid_in),
        .drawx         (drawx),
        .drawy         (drawy),
        .bg_pixel      (bg_pixel),
        .pix_valid_out (pix_valid_out),
        .pix_out       (pix_out),
        .spr_address   (spr_address),
        .spr_chipselect(spr_chipselect),
        .spr_clken     (spr_clken),
        .spr_readdata  (spr_readdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Sprite RAMs, 1-cycle read latency
    logic [15:0] ram [NS][2048];
    always @(posedge clk) begin
        for (int n = 0; n < NS; n++) begin
            if (spr_clken[n]) spr_readdata[n*PW +: PW] <= ram[n][spr_address[n*AW +: AW]];
        end
    end

    // Register model
    int          sh_ctrl [NS], sh_x [NS], sh_y [NS];
    int          act_ctrl[NS], act_x[NS], act_y[NS];
    bit          pending;
    logic [NS-1:0] exp_coll;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [15:0] pix;
        int          due;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            check_eq("pix_valid_out", 32'(pix_valid_out), 32'd1);
            check_eq("pix_out", 32'(pix_out), 32'(sb[0].pix));
            void'(sb.pop_front());
        end else if (pix_valid_out) begin
            check_eq("stray_valid", 32'(pix_valid_out), 32'd0);
        end
    end

    function automatic logic [15:0] model_pix(input int dx, input int dy, input logic [15:0] bg,
                                              output logic [NS-1:0] opq);
        logic [15:0] res;
        logic [15:0] d;
        bit          found;
        int          sx, sy, rx, ry, ax, ay;
        res = bg;
        found = 0;
        opq = '0;
        for (int n = 0; n < NS; n++) begin
            if ((act_ctrl[n] & 1) != 0) begin
                sx = (act_x[n] >= 1024) ? act_x[n] - 2048 : act_x[n];
                sy = (act_y[n] >= 1024) ? act_y[n] - 2048 : act_y[n];
                rx = dx - sx;
                ry = dy - sy;
                if (rx >= 0 && rx < SW && ry >= 0 && ry < SH) begin
                    ax = ((act_ctrl[n] & 2) != 0) ? SW - 1 - rx : rx;
                    ay = ((act_ctrl[n] & 4) != 0) ? SH - 1 - ry : ry;
                    d = ram[n][(ay * SW + ax) % 2048];
                    if (d != KEY) begin
                        opq[n] = 1'b1;
                        if (!found) begin
                            res = d;
                            found = 1;
                        end
                    end
                end
            end
        end
        return res;
    endfunction

    function automatic void model_commit();
        if (pending) begin
            for (int n = 0; n < NS; n++) begin
                act_ctrl[n] = sh_ctrl[n];
                act_x[n]    = sh_x[n];
                act_y[n]    = sh_y[n];
            end
            pending = 0;
        end
    endfunction

    function automatic void model_reset();
        for (int n = 0; n < NS; n++) begin
            sh_ctrl[n] = 0; sh_x[n] = 0; sh_y[n] = 0;
            act_ctrl[n] = 0; act_x[n] = 0; act_y[n] = 0;
        end
        pending = 0;
        exp_coll = '0;
    endfunction

    task automatic set_idle();
        pix_valid_in         = 1'b0;
        frame_start          = 1'b0;
        avs_if.avs_read      = 1'b0;
        avs_if.avs_write     = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            set_idle();
        end
    endtask

    task automatic av_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        set_idle();
        avs_if.avs_address   = a;
        avs_if.avs_writedata = d;
        avs_if.avs_write     = 1'b1;
        if (int'(a) < 4 * NS) begin
            if (a[1:0] == 2'd0) sh_ctrl[a[7:2]] = int'(d[2:0]);
            if (a[1:0] == 2'd1) begin
                sh_x[a[7:2]] = int'(d[10:0]);
                sh_y[a[7:2]] = int'(d[26:16]);
            end
        end else if (a == 8'hFD) begin
            exp_coll = exp_coll & ~d[NS-1:0];
        end else if (a == 8'hFF && d[0]) begin
            pending = 1;
        end
    endtask

    task automatic av_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        set_idle();
        avs_if.avs_address = a;
        avs_if.avs_read    = 1'b1;
        @(negedge clk);
        set_idle();
        d = avs_if.avs_readdata;
    endtask

    task automatic check_reg(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        av_read(a, d);
        check_eq(tag, d, exp);
    endtask

    task automatic frame_pulse();
        @(negedge clk);
        set_idle();
        frame_start = 1'b1;
        model_commit();
    endtask

    task automatic commit_and_frame();
        @(negedge clk);
        set_idle();
        avs_if.avs_address   = 8'hFF;
        avs_if.avs_writedata = 32'd1;
        avs_if.avs_write     = 1'b1;
        frame_start          = 1'b1;
        model_commit();
        pending = 1;
    endtask

    task automatic pix_req(input int x, input int y, input logic [15:0] bg);
        logic [NS-1:0] o;
        logic [15:0]   e;
        @(negedge clk);
        set_idle();
        pix_valid_in = 1'b1;
        drawx        = 10'(x);
        drawy        = 10'(y);
        bg_pixel     = bg;
        e = model_pix(x, y, bg, o);
        if ($countones(o) >= 2) exp_coll = exp_coll | o;
        sb.push_back('{pix: e, due: cyc + 3});
    endtask

    task automatic req_check_addr(input string tag, input int x, input int y, input logic [15:0] bg,
                                  input int n, input int exp_addr, input bit exp_cs);
        pix_req(x, y, bg);
        @(negedge clk);
        set_idle();
        check_eq({tag, "_cs"}, 32'(spr_chipselect[n]), 32'(exp_cs));
        check_eq({tag, "_clken"}, 32'(spr_clken[n]), 32'(exp_cs));
        if (exp_cs) check_eq({tag, "_addr"}, 32'(spr_address[n*AW +: AW]), 32'(exp_addr));
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() > 0 && t < 50) begin
            @(negedge clk);
            set_idle();
            t++;
        end
        if (sb.size() > 0) check_eq("drain_timeout", 32'(sb.size()), 32'd0);
        idle(3);
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_idle();
        rst = 1'b1;
        sb.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        for (int n = 0; n < NS; n++)
            for (int a = 0; a < 2048; a++)
                ram[n][a] = 16'((n << 11) ^ a ^ 16'h0100);
        model_reset();
        drawx = '0; drawy = '0; bg_pixel = '0;
        avs_if.avs_address = '0; avs_if.avs_writedata = '0;
        set_idle();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", 32'(pix_valid_out), 32'd0);
        check_eq("rst_pix", 32'(pix_out), 32'd0);
        check_eq("rst_cs", 32'(spr_chipselect), 32'd0);
        check_eq("rst_clken", 32'(spr_clken), 32'd0);
        check_eq("rst_rdata", avs_if.avs_readdata, 32'd0);
        rst = 1'b0;
        check_reg("rst_status", 8'hFE, 32'd0);
        check_reg("rst_coll", 8'hFD, 32'd0);
        check_reg("rst_ctrl0", 8'h00, 32'd0);

        // Background pass-through, three back-to-back requests
        pix_req(10, 10, 16'h1234);
        pix_req(11, 10, 16'h1234);
        pix_req(12, 10, 16'h1234);
        drain();

        // Sprite 0 at (100,50): shadow only until commit + frame_start
        av_write(8'h01, (32'd50 << 16) | 32'd100);
        av_write(8'h00, 32'd1);
        pix_req(100, 50, 16'hAAAA);
        drain();
        check_reg("status_idle", 8'hFE, 32'd0);
        av_write(8'hFF, 32'd1);
        check_reg("status_pending", 8'hFE, 32'd1);
        frame_pulse();
        check_reg("status_cleared", 8'hFE, 32'd0);
        ram[0][0] = 16'h07E0;
        req_check_addr("s0_origin", 100, 50, 16'h5555, 0, 0, 1'b1);
        req_check_addr("s0_right", 132, 50, 16'h5555, 0, 0, 1'b0);
        drain();
        check_reg("pos_rb", 8'h01, (32'd50 << 16) | 32'd100);
        check_reg("ctrl_rb", 8'h00, 32'd1);
        check_reg("rsvd_rb", 8'h02, 32'd0);

        // Both flips at origin
        av_write(8'h00, 32'd7);
        av_write(8'h01, 32'd0);
        av_write(8'hFF, 32'd1);
        frame_pulse();
        req_check_addr("flip", 0, 0, 16'h0F0F, 0, 2047, 1'b1);
        drain();

        // Overlap of sprites 0 and 1 at (200,100)
        av_write(8'h00, 32'd1);
        av_write(8'h01, (32'd100 << 16) | 32'd200);
        av_write(8'h04, 32'd1);
        av_write(8'h05, (32'd100 << 16) | 32'd200);
        av_write(8'hFF, 32'd1);
        frame_pulse();
        ram[0][0] = KEY;
        ram[1][0] = 16'h001F;
        pix_req(200, 100, 16'h2222);
        drain();
        check_reg("coll_none", 8'hFD, 32'd0);
        pix_req(201, 100, 16'h2222);
        drain();
        check_reg("coll_both", 8'hFD, 32'h3);
        av_write(8'hFD, 32'h1);
        check_reg("coll_w1c", 8'hFD, 32'h2);

        // Sprite 2 partially off the left edge
        av_write(8'h08, 32'd1);
        av_write(8'h09, (32'd300 << 16) | 32'h7F6);
        av_write(8'hFF, 32'd1);
        frame_pulse();
        req_check_addr("negx", 0, 300, 16'h3333, 2, 10, 1'b1);
        req_check_addr("negx_above", 0, 299, 16'h3333, 2, 0, 1'b0);
        drain();

        // COMMIT write coinciding with frame_start stays pending
        av_write(8'h09, (32'd300 << 16) | 32'd5);
        commit_and_frame();
        check_reg("commit_fs_pending", 8'hFE, 32'd1);
        pix_req(5, 300, 16'h4444);
        drain();
        frame_pulse();
        check_reg("commit_fs_done", 8'hFE, 32'd0);
        pix_req(5, 300, 16'h4444);
        drain();

        // Random traffic over the overlapping region, plus a flipped sprite 3
        av_write(8'h0C, 32'd5);
        av_write(8'h0D, (32'd130 << 16) | 32'd220);
        av_write(8'hFF, 32'd1);
        frame_pulse();
        av_write(8'hFD, 32'hFF);
        for (int i = 0; i < 40; i++)
            pix_req(190 + int'($urandom_range(0, 50)), 95 + int'($urandom_range(0, 75)),
                    16'($urandom_range(0, 16'hFFFF)));
        for (int i = 0; i < 8; i++)
            pix_req(int'($urandom_range(0, 40)), 290 + int'($urandom_range(0, 20)), 16'h5A5A);
        drain();
        check_reg("coll_random", 8'hFD, 32'(exp_coll));

        // Reset with requests in flight
        pix_req(200, 100, 16'h6666);
        pix_req(201, 100, 16'h6666);
        do_reset();
        idle(6);
        check_eq("post_rst_valid", 32'(pix_valid_out), 32'd0);
        check_reg("post_rst_ctrl0", 8'h00, 32'd0);
        check_reg("post_rst_coll", 8'hFD, 32'd0);
        pix_req(200, 100, 16'h1234);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
